// File: rtl/vedic_div_pkg.sv
// ============================================================================
// vedic_div_pkg : shared types and constants for the radix-4 Vedic divider
// Revision: 1.0
// ============================================================================
`default_nettype none

package vedic_div_pkg;

    localparam int N_DEF   = 8;
    localparam int M_DEF   = 4;
    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vedic_div_radix4_seq_if.sv
// ============================================================================
// vedic_div_radix4_seq_if : request / result / digit-stream bundle of the divider
// Revision: 1.0
// ============================================================================
`default_nettype none

interface vedic_div_radix4_seq_if
    import vedic_div_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
);
    logic               start;
    logic [N-1:0]       dividend;
    logic [M-1:0]       divisor;
    logic               busy;
    logic               done;
    logic [N-1:0]       quotient;
    logic [M-1:0]       remainder;
    logic               div_by_zero;
    logic [DIGIT_W-1:0] digit_out;
    logic               digit_valid;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, digit_out, digit_valid
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, digit_out, digit_valid
    );
endinterface

`default_nettype wire

// File: rtl/radix4_digit_sel.sv
// ============================================================================
// radix4_digit_sel : picks the largest q in {0..3} with q*d <= t, returns t - q*d
// Revision: 1.0
// ============================================================================
`default_nettype none

module radix4_digit_sel
    import vedic_div_pkg::*;
#(
    parameter int M = M_DEF
) (
    input  logic [M+1:0]       t,
    input  logic [M-1:0]       d,
    output logic [DIGIT_W-1:0] q,
    output logic [M+1:0]       rem
);

    logic [M+1:0] w_d1;
    logic [M+1:0] w_d2;
    logic [M+1:0] w_d3;

    // 3d < 2^(M+2) for any M-bit d, so M+2 bits never overflow
    assign w_d1 = (M+2)'(d);
    assign w_d2 = w_d1 << 1;
    assign w_d3 = w_d2 + w_d1;

    always_comb begin
        q   = 2'd0;
        rem = t;
        if (t >= w_d3) begin
            q   = 2'd3;
            rem = t - w_d3;
        end else if (t >= w_d2) begin
            q   = 2'd2;
            rem = t - w_d2;
        end else if (t >= w_d1) begin
            q   = 2'd1;
            rem = t - w_d1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vedic_div_radix4_seq.sv
// ============================================================================
// vedic_div_radix4_seq : sequential unsigned divider, two quotient bits per clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module vedic_div_radix4_seq
    import vedic_div_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    vedic_div_radix4_seq_if.slave      bus
);

    localparam int              ITERS    = N / 2;
    localparam int              CNT_W    = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [N-1:0]         r_dvd_sh;
    logic [M-1:0]         r_dsr;
    logic [M+1:0]         r_prem;
    logic [N-1:0]         r_quot;
    logic [M-1:0]         r_rem;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;
    logic [DIGIT_W-1:0]   r_digit;
    logic                 r_dvalid;

    logic [M+1:0]         w_t;
    logic [M+1:0]         w_next_prem;
    logic [DIGIT_W-1:0]   w_q;

    // Previous remainder fits in M bits, so shifting left by two within M+2 loses nothing
    assign w_t = (r_prem << 2) | (M+2)'(r_dvd_sh[N-1 -: 2]);

    radix4_digit_sel #(.M(M)) u_sel (
        .t   (w_t),
        .d   (r_dsr),
        .q   (w_q),
        .rem (w_next_prem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dvd_sh <= '0;
            r_dsr    <= '0;
            r_prem   <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_digit  <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_dvalid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_dvd_sh <= bus.dividend;
                        r_dsr    <= bus.divisor;
                        r_prem   <= '0;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        if (bus.divisor == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_dbz   <= 1'b1;
                            r_quot  <= '1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_dbz   <= 1'b0;
                            r_quot  <= '0;
                        end
                    end else if (r_state == DONE) begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_prem   <= w_next_prem;
                    r_dvd_sh <= r_dvd_sh << 2;
                    r_quot   <= (r_quot << 2) | N'(w_q);
                    r_digit  <= w_q;
                    r_dvalid <= 1'b1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_rem   <= w_next_prem[M-1:0];
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
    assign bus.digit_out   = r_digit;
    assign bus.digit_valid = r_dvalid;

endmodule

`default_nettype wire

// File: tb/tb_vedic_div_radix4_seq.sv
// ============================================================================
// tb_vedic_div_radix4_seq : directed self-checking bench for the radix-4 divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vedic_div_radix4_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    vedic_div_radix4_seq_if #(.N(8), .M(4)) bus ();

    vedic_div_radix4_seq #(.N(8), .M(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
        chk("launch_busy", 32'(bus.busy), 32'd1);
        chk("launch_done", 32'(bus.done), 32'd0);
        chk("launch_dv", 32'(bus.digit_valid), 32'd0);
    endtask

    // digs packs the expected digits MSB-first; at iteration raise_at start is raised with 9/2
    task automatic collect(input string tag, input logic [7:0] digs, input logic [7:0] q,
                           input logic [3:0] r, input int raise_at);
        logic [7:0] d;
        d = digs;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_dv"}, 32'(bus.digit_valid), 32'd1);
            chk({tag, "_digit"}, 32'(bus.digit_out), 32'(d[7-2*i -: 2]));
            chk({tag, "_busy"}, 32'(bus.busy), (i < 3) ? 32'd1 : 32'd0);
            chk({tag, "_done"}, 32'(bus.done), (i == 3) ? 32'd1 : 32'd0);
            if (i == 0) bus.start = 1'b0;
            if (i == raise_at) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd9;
                bus.divisor  = 4'd2;
            end
        end
        chk({tag, "_quot"}, 32'(bus.quotient), 32'(q));
        chk({tag, "_rem"}, 32'(bus.remainder), 32'(r));
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
    endtask

    task automatic after_done(input string tag);
        tick();
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        chk({tag, "_dv_drop"}, 32'(bus.digit_valid), 32'd0);
        chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dv", 32'(bus.digit_valid), 32'd0);
        chk("rst_digit", 32'(bus.digit_out), 32'd0);
        chk("rst_quot", 32'(bus.quotient), 32'd0);
        chk("rst_rem", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        // 200 / 7 = 28 r 4, digits 0 1 3 0
        launch(8'd200, 4'd7);
        collect("d200_7", 8'b00_01_11_00, 8'd28, 4'd4, -1);
        after_done("d200_7");

        // 255 / 1 = 255 r 0
        launch(8'd255, 4'd1);
        collect("d255_1", 8'b11_11_11_11, 8'd255, 4'd0, -1);
        after_done("d255_1");

        // 5 / 15 = 0 r 5
        launch(8'd5, 4'd15);
        collect("d5_15", 8'b00_00_00_00, 8'd0, 4'd5, -1);
        after_done("d5_15");

        // 100 / 0: immediate completion, no digits
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd0;
        tick();
        bus.start = 1'b0;
        chk("dz_done", 32'(bus.done), 32'd1);
        chk("dz_dbz", 32'(bus.div_by_zero), 32'd1);
        chk("dz_quot", 32'(bus.quotient), 32'd255);
        chk("dz_rem", 32'(bus.remainder), 32'd0);
        chk("dz_dv", 32'(bus.digit_valid), 32'd0);
        chk("dz_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("dz_done_drop", 32'(bus.done), 32'd0);
        chk("dz_dv_after", 32'(bus.digit_valid), 32'd0);
        chk("dz_dbz_held", 32'(bus.div_by_zero), 32'd1);
        chk("dz_quot_held", 32'(bus.quotient), 32'd255);

        // start re-pulsed mid-run with 255/1 is ignored; 9/2 held through done runs back-to-back
        launch(8'd200, 4'd7);
        bus.start    = 1'b1;
        bus.dividend = 8'd255;
        bus.divisor  = 4'd1;
        collect("ign200_7", 8'b00_01_11_00, 8'd28, 4'd4, 2);
        tick();
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_done", 32'(bus.done), 32'd0);
        chk("b2b_dv", 32'(bus.digit_valid), 32'd0);
        chk("b2b_quot_clr", 32'(bus.quotient), 32'd0);
        collect("d9_2", 8'b00_00_01_00, 8'd4, 4'd1, -1);
        after_done("d9_2");

        // asynchronous reset after the second digit of 200/7
        launch(8'd200, 4'd7);
        tick();
        chk("pre_rst_digit0", 32'(bus.digit_out), 32'd0);
        tick();
        chk("pre_rst_digit1", 32'(bus.digit_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.done), 32'd0);
        chk("ar_dv", 32'(bus.digit_valid), 32'd0);
        chk("ar_digit", 32'(bus.digit_out), 32'd0);
        chk("ar_quot", 32'(bus.quotient), 32'd0);
        chk("ar_rem", 32'(bus.remainder), 32'd0);
        chk("ar_dbz", 32'(bus.div_by_zero), 32'd0);
        tick();
        tick();
        chk("ar_no_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("ar_still_idle", 32'(bus.busy), 32'd0);
        chk("ar_still_no_done", 32'(bus.done), 32'd0);

        // 50 / 3 = 16 r 2
        launch(8'd50, 4'd3);
        collect("d50_3", 8'b00_01_00_00, 8'd16, 4'd2, -1);
        after_done("d50_3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
